// File: rtl/io_target_responder.sv
// io_target_responder
// Device-side responder behind one chip select of the I/O bridge. It holds
// NREGS 32-bit control registers; the top one is a read-only window onto
// status_i. The responder inserts WAIT_STATES cycles before acknowledging,
// keeps ack_o high until the strobe falls, and then zeroes the data bus.
module io_target_responder #(
   parameter int          NREGS       = 16,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] REG_RST     = 32'h0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                cs_i,
   input  logic                cyc_i,
   input  logic                stb_i,
   input  logic                we_i,
   input  logic [3:0]          sel_i,
   input  logic [31:0]         adr_i,
   input  logic [31:0]         dat_i,
   output logic                ack_o,
   output logic                stall_o,
   output logic [31:0]         dat_o,
   input  logic [31:0]         status_i,
   output logic [NREGS*32-1:0] regs_o,
   output logic [NREGS-1:0]    wr_strobe_o
);

   localparam int             IW         = $clog2(NREGS);
   localparam logic [IW-1:0]  STATUS_IDX = IW'(NREGS - 1);
   localparam logic [3:0]     WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t         state;
   state_t         next_state;
   logic [3:0]     cnt;
   logic [3:0]     cnt_next;
   logic           capture;
   logic           commit;

   // Request fields latched in IDLE so the bridge may change them while we wait
   logic           cap_we;
   logic [3:0]     cap_sel;
   logic [IW-1:0]  cap_idx;
   logic [31:0]    cap_dat;

   // Fields of the transfer being committed: live bus in IDLE, latched copy later
   logic           x_we;
   logic [3:0]     x_sel;
   logic [IW-1:0]  x_idx;
   logic [31:0]    x_dat;

   logic [31:0]    rd_data;
   logic           ack_next;
   logic           stall_next;
   logic [31:0]    dat_next;
   logic [NREGS-1:0] strobe_next;

   logic [31:0]    regs [NREGS-1];

   // Address bits outside the register index are deliberately ignored
   logic           unused_adr;
   assign unused_adr = ^{adr_i[31:IW+2], adr_i[1:0]};

   // Byte-lane merge: lanes with be set take new data, others keep the old value
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            res[b*8 +: 8] = new_val[b*8 +: 8];
         end else begin
            res[b*8 +: 8] = old_val[b*8 +: 8];
         end
      end
      return res;
   endfunction

   // Select live bus fields in IDLE (zero-wait commit) or the latched request otherwise
   always_comb begin
      if (state == ST_IDLE) begin
         x_we  = we_i;
         x_sel = sel_i;
         x_idx = adr_i[IW+1:2];
         x_dat = dat_i;
      end else begin
         x_we  = cap_we;
         x_sel = cap_sel;
         x_idx = cap_idx;
         x_dat = cap_dat;
      end
   end

   // Flat register view; the top slot always mirrors live status
   always_comb begin
      regs_o = '0;
      for (int k = 0; k < NREGS - 1; k++) begin
         regs_o[k*32 +: 32] = regs[k];
      end
      regs_o[(NREGS-1)*32 +: 32] = status_i;
   end

   // Read mux over the flat view, so the status slot is sampled at commit time
   always_comb begin
      rd_data = regs_o[32*int'(x_idx) +: 32];
   end

   // Next-state logic: request qualification, wait countdown, abort and ack release
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      capture    = 1'b0;
      commit     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cs_i && cyc_i && stb_i) begin
               capture = 1'b1;
               if (WAIT_STATES == 0) begin
                  next_state = ST_ACK;
                  commit     = 1'b1;
               end else begin
                  next_state = ST_WAIT;
                  cnt_next   = WAIT_LOAD;
               end
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!cyc_i) begin
               next_state = ST_IDLE;
               cnt_next   = 4'd0;
            end else if (cnt == 4'd0) begin
               next_state = ST_ACK;
               commit     = 1'b1;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         ST_ACK: begin
            if (!stb_i) begin
               next_state = ST_IDLE;
            end else begin
               next_state = ST_ACK;
            end
         end
         default: begin
            next_state = ST_IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   // Output values for the next cycle, derived from the upcoming state
   always_comb begin
      ack_next   = (next_state == ST_ACK);
      stall_next = (next_state != ST_IDLE);
      if (commit && x_we && (x_idx != STATUS_IDX)) begin
         strobe_next = {{(NREGS-1){1'b0}}, 1'b1} << x_idx;
      end else begin
         strobe_next = '0;
      end
      if (commit) begin
         dat_next = x_we ? 32'h0 : rd_data;
      end else if (next_state == ST_ACK) begin
         dat_next = dat_o;
      end else begin
         dat_next = 32'h0;
      end
   end

   // State, counter and registered bus outputs
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state       <= ST_IDLE;
         cnt         <= 4'd0;
         ack_o       <= 1'b0;
         stall_o     <= 1'b0;
         dat_o       <= 32'h0;
         wr_strobe_o <= '0;
      end else begin
         state       <= next_state;
         cnt         <= cnt_next;
         ack_o       <= ack_next;
         stall_o     <= stall_next;
         dat_o       <= dat_next;
         wr_strobe_o <= strobe_next;
      end
   end

   // Latch the request fields when a request is accepted in IDLE
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cap_we  <= 1'b0;
         cap_sel <= 4'h0;
         cap_idx <= '0;
         cap_dat <= 32'h0;
      end else if (capture) begin
         cap_we  <= we_i;
         cap_sel <= sel_i;
         cap_idx <= adr_i[IW+1:2];
         cap_dat <= dat_i;
      end
   end

   // Writable register file: byte-masked update on the edge that enters ACK
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int k = 0; k < NREGS - 1; k++) begin
            regs[k] <= REG_RST;
         end
      end else begin
         for (int k = 0; k < NREGS - 1; k++) begin
            if (commit && x_we && (x_idx == IW'(k))) begin
               regs[k] <= merge_bytes(regs[k], x_dat, x_sel);
            end
         end
      end
   end

endmodule
